aes_key_expand_seq: RTL and testbench
=====================================

// Module: aes_key_expand_seq
// PURPOSE
//  Sequential AES key-schedule engine for AES-128/192/256 (FIPS-197).
//  - Accepts a key and expands it into a 60x32 word buffer.
//  - Any round key can then be read at random, including while expansion is still running.
//  - Replaces the per-round combinational generator ahead of the round datapath.
//  - Area is one or two word generators instead of 14 parallel round-key stages.
// PARAMETERS
//  WORDS_PER_CYCLE  1  key words generated per cycle. Legal values: 1 or 2. Other values are an elaboration error.
//  REG_READ         1  1: rd_key/rd_valid registered, 1-cycle latency. 0: combinational read.
// PORTS
//  clk         in   1    single clock; all state on rising edge
//  reset       in   1    synchronous, active-high
//  start       in   1    request expansion; accepted when start & ready
//  mode        in   2    00 AES-128, 01 AES-192, 10 AES-256, 11 illegal
//  key_in      in   256  MSB-aligned key; w[0]=key_in[255:224]; 128: [255:128], 192: [255:64]
//  ready       out  1    idle, start will be accepted
//  busy        out  1    expansion in progress
//  done        out  1    1-cycle pulse, all words written
//  err         out  1    1-cycle pulse, start with mode==11 (rejected)
//  num_rounds  out  4    Nr of last accepted key: 10/12/14
//  rd_round    in   4    round-key index to read, 0..Nr
//  rd_key      out  128  {w[4r],w[4r+1],w[4r+2],w[4r+3]}
//  rd_valid    out  1    all four words of rd_round already written, and rd_round<=Nr
// BEHAVIOUR
//  - Reset values:
//    - ready=1; busy=0, done=0, err=0.
//    - num_rounds=10, rd_key=0, rd_valid=0.
//    - Write pointer wp=0; buffer contents don't-care.
//  - States: IDLE -> LOAD -> GEN -> IDLE.
//  - IDLE:
//    - start & ready & mode!=11 -> LOAD; latch mode.
//    - Nk=4/6/8, total words T=44/52/60; num_rounds updates next cycle.
//    - start with mode==11 -> err pulse next cycle; stay IDLE; buffer unchanged.
//  - LOAD (1 cycle):
//    - Write w[0..Nk-1] from the key captured at acceptance; wp<=Nk.
//    - Rcon<=8'h01.
//  - GEN, per word i (i=wp, wp+1 when WORDS_PER_CYCLE=2; second word chained from first):
//    - i%Nk==0: t=SubWord(RotWord(w[i-1]))^{Rcon,24'h0}; then Rcon<=xtime(Rcon).
//    - Nk==8 & i%Nk==4: t=SubWord(w[i-1]).
//    - else t=w[i-1].
//    - w[i]=w[i-Nk]^t; wp advances by WORDS_PER_CYCLE.
//    - xtime = {Rcon[6:0],1'b0} ^ (Rcon[7] ? 8'h1b : 0).
//  - Leaving GEN:
//    - wp reaches T -> IDLE; done pulses that cycle+1.
//    - T-Nk (40/46/52) is even, so the 2-word mode never overruns.
//  - Latency, start accepted at cycle 0:
//    - done at cycle 1+(T-Nk)/WORDS_PER_CYCLE+1.
//    - WORDS_PER_CYCLE=1: AES-128 at 42, AES-256 at 54.
//  - ready=0 and busy=1 from cycle 1 until the done cycle; start is ignored while busy.
//  - rd_valid=(4*rd_round+3 < wp) & (rd_round<=num_rounds).
//    - Early round keys are usable mid-expansion.
//    - A new start invalidates everything: wp=0 from the acceptance cycle.
//  - rd_round>Nr: rd_valid=0; rd_key don't-care.
//  - reset mid-expansion: return to IDLE next cycle; no done pulse; rd_valid=0.
//  - start in the done cycle: accepted, since ready=1 in IDLE.
// STRUCTURE
//  - Shared package aes_pkg:
//    - aes_mode_t enum: AES128/AES192/AES256.
//    - Localparams NK[], NR[], TOTAL_WORDS[].
//    - Function xtime.
//  - Sub-module aes_subword: 4 parallel sboxes, 32b in/out, combinational.
//    - One instance per generated word.
//  - Buffer: 60x32 register array, written at wp (and wp+1).
// TESTING
//  - AES-128, key 2b7e1516 28aed2a6 abf71588 09cf4f3c:
//    - rd_round=1 -> a0fafe17 88542cb1 23a33939 2a6c7605.
//    - rd_round=10 -> d014f9a8 c9ee2589 e13f0cc8 b6630ca6.
//    - done at cycle 42.
//  - AES-192, key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b:
//    - rd_round=12 -> e98ba06f 448c773c 8ecc7204 01002202.
//    - num_rounds=12.
//  - AES-256, key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4:
//    - rd_round=14 -> fe4890d1 e6188d0b 046df344 706c631e.
//  - Poll rd_round=2 during AES-128 expansion:
//    - rd_valid rises exactly when wp>=12.
//    - rd_round=11 -> rd_valid=0 permanently.
//  - mode=11 start -> err pulse, ready stays 1, buffer unchanged.
//  - start while busy -> ignored.
//  - reset at cycle 20 -> IDLE, no done pulse.
//  - Repeat all vectors with WORDS_PER_CYCLE=2 and REG_READ=0.
//    - Expected: same keys; AES-128 done at cycle 22.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES key-schedule types and constants: key modes, per-mode word counts, engine states.
// Purely declarative; no latency or flow control of its own.
package aes_pkg;

    typedef enum logic [1:0] {
        AES128 = 2'b00,
        AES192 = 2'b01,
        AES256 = 2'b10
    } aes_mode_t;

    localparam logic [1:0] MODE_ILLEGAL = 2'b11;

    // Indexed by mode; entry 3 is never selected for a latched mode.
    localparam logic [3:0][5:0] NK          = {6'd4,  6'd8,  6'd6,  6'd4};
    localparam logic [3:0][3:0] NR          = {4'd10, 4'd14, 4'd12, 4'd10};
    localparam logic [3:0][5:0] TOTAL_WORDS = {6'd44, 6'd60, 6'd52, 6'd44};

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LOAD = 2'b01,
        S_GEN  = 2'b10
    } kx_state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_key_expand_seq_if.sv
// Control, key-load and round-key read bundle of the key-schedule engine.
// start is taken only while ready; reads are always accepted and never stall.
interface aes_key_expand_seq_if;
    logic         start;
    logic [1:0]   mode;
    logic [255:0] key_in;
    logic         ready;
    logic         busy;
    logic         done;
    logic         err;
    logic [3:0]   num_rounds;
    logic [3:0]   rd_round;
    logic [127:0] rd_key;
    logic         rd_valid;

    modport master (
        output start, mode, key_in, rd_round,
        input  ready, busy, done, err, num_rounds, rd_key, rd_valid
    );

    modport slave (
        input  start, mode, key_in, rd_round,
        output ready, busy, done, err, num_rounds, rd_key, rd_valid
    );
endinterface

// File: rtl/aes_subword.sv
// Four parallel AES S-boxes applied to a 32-bit word; combinational, zero latency, no flow control.
module aes_subword (
    input  logic [31:0] i_word,
    output logic [31:0] o_word
);

    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign o_word = {SBOX[i_word[31:24]], SBOX[i_word[23:16]], SBOX[i_word[15:8]], SBOX[i_word[7:0]]};

endmodule

// File: rtl/aes_key_expand_seq.sv
// Sequential AES-128/192/256 key schedule into a 60-word buffer; done 2+(T-Nk)/WORDS_PER_CYCLE cycles after start.
// start is taken only while ready; round-key reads never stall and are valid as soon as their words exist.
module aes_key_expand_seq
    import aes_pkg::*;
#(
    parameter int WORDS_PER_CYCLE = 1,
    parameter bit REG_READ        = 1
) (
    input  logic                clk,
    input  logic                reset,
    aes_key_expand_seq_if.slave kx
);

    if (WORDS_PER_CYCLE != 1 && WORDS_PER_CYCLE != 2) begin : g_bad_wpc
        $error("aes_key_expand_seq: WORDS_PER_CYCLE must be 1 or 2");
    end

    kx_state_t    r_state;
    aes_mode_t    r_mode;
    logic [255:0] r_key;
    logic [5:0]   r_wp;
    logic [2:0]   r_kidx;
    logic [7:0]   r_rcon;
    logic [31:0]  r_buf [60];
    logic         r_ready;
    logic         r_busy;
    logic         r_done;
    logic         r_err;
    logic [3:0]   r_num_rounds;

    logic [5:0]   w_nk;
    logic [5:0]   w_total;
    logic         w_accept;
    logic         w_reject;
    logic [5:0]   w_kidx_sum;
    logic [5:0]   w_wp_next;
    logic [7:0]   w_rcon_next;
    logic [WORDS_PER_CYCLE-1:0][31:0] w_gen_word;

    assign w_nk       = NK[r_mode];
    assign w_total    = TOTAL_WORDS[r_mode];
    assign w_accept   = kx.start & r_ready & (kx.mode != MODE_ILLEGAL);
    assign w_reject   = kx.start & r_ready & (kx.mode == MODE_ILLEGAL);
    assign w_kidx_sum = {3'b000, r_kidx} + 6'(WORDS_PER_CYCLE);
    assign w_wp_next  = r_wp + 6'(WORDS_PER_CYCLE);

    // Word g of a cycle is i = wp+g; word 1 chains off word 0 rather than the buffer.
    for (genvar g = 0; g < WORDS_PER_CYCLE; g++) begin : g_word
        logic [31:0] w_prev;
        logic [31:0] w_back;
        logic [31:0] w_sub_in;
        logic [31:0] w_sub_out;
        logic [31:0] w_word;
        logic [2:0]  w_kidx;
        logic [7:0]  w_rcon_in;
        logic [7:0]  w_rcon_out;
        logic [5:0]  w_idx;

        if (g == 0) begin : g_head
            assign w_prev    = r_buf[r_wp - 6'd1];
            assign w_kidx    = r_kidx;
            assign w_rcon_in = r_rcon;
        end else begin : g_chain
            // First word always sits at an even offset since Nk is even, so this never wraps.
            assign w_prev    = g_word[g-1].w_word;
            assign w_kidx    = g_word[g-1].w_kidx + 3'd1;
            assign w_rcon_in = g_word[g-1].w_rcon_out;
        end

        assign w_idx    = r_wp + 6'(g);
        assign w_back   = r_buf[w_idx - w_nk];
        assign w_sub_in = (w_kidx == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

        aes_subword u_subword (
            .i_word (w_sub_in),
            .o_word (w_sub_out)
        );

        always_comb begin
            w_word     = w_back ^ w_prev;
            w_rcon_out = w_rcon_in;
            if (w_kidx == 3'd0) begin
                w_word     = w_back ^ w_sub_out ^ {w_rcon_in, 24'h000000};
                w_rcon_out = xtime(w_rcon_in);
            end else if (w_nk == 6'd8 && w_kidx == 3'd4) begin
                w_word = w_back ^ w_sub_out;
            end
        end

        assign w_gen_word[g] = w_word;
    end

    assign w_rcon_next = g_word[WORDS_PER_CYCLE-1].w_rcon_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_mode       <= AES128;
            r_key        <= '0;
            r_wp         <= '0;
            r_kidx       <= '0;
            r_rcon       <= 8'h01;
            r_ready      <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_num_rounds <= 4'd10;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mode       <= aes_mode_t'(kx.mode);
                        r_key        <= kx.key_in;
                        r_wp         <= '0;
                        r_num_rounds <= NR[kx.mode];
                        r_ready      <= 1'b0;
                        r_busy       <= 1'b1;
                        r_state      <= S_LOAD;
                    end else if (w_reject) begin
                        r_err <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_wp    <= w_nk;
                    r_kidx  <= '0;
                    r_rcon  <= 8'h01;
                    r_state <= S_GEN;
                end
                S_GEN: begin
                    r_wp   <= w_wp_next;
                    r_kidx <= 3'((w_kidx_sum >= w_nk) ? (w_kidx_sum - w_nk) : w_kidx_sum);
                    r_rcon <= w_rcon_next;
                    if (w_wp_next == w_total) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Buffer contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (!reset && r_state == S_LOAD) begin
            for (int k = 0; k < 8; k++) begin
                if (6'(k) < w_nk) begin
                    r_buf[k] <= r_key[255 - 32*k -: 32];
                end
            end
        end else if (!reset && r_state == S_GEN) begin
            for (int g = 0; g < WORDS_PER_CYCLE; g++) begin
                r_buf[r_wp + 6'(g)] <= w_gen_word[g];
            end
        end
    end

    logic         w_rd_valid;
    logic [127:0] w_rd_raw;
    logic [127:0] w_rd_key;

    assign w_rd_valid = ({kx.rd_round, 2'b11} < r_wp) && (kx.rd_round <= r_num_rounds);
    assign w_rd_raw   = {r_buf[{kx.rd_round, 2'b00}], r_buf[{kx.rd_round, 2'b01}],
                         r_buf[{kx.rd_round, 2'b10}], r_buf[{kx.rd_round, 2'b11}]};
    assign w_rd_key   = w_rd_valid ? w_rd_raw : 128'h0;

    if (REG_READ) begin : g_rd_reg
        logic [127:0] r_rd_key;
        logic         r_rd_valid;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_rd_key   <= '0;
                r_rd_valid <= 1'b0;
            end else begin
                r_rd_key   <= w_rd_key;
                r_rd_valid <= w_rd_valid;
            end
        end

        assign kx.rd_key   = r_rd_key;
        assign kx.rd_valid = r_rd_valid;
    end else begin : g_rd_comb
        assign kx.rd_key   = w_rd_key;
        assign kx.rd_valid = w_rd_valid;
    end

    assign kx.ready      = r_ready;
    assign kx.busy       = r_busy;
    assign kx.done       = r_done;
    assign kx.err        = r_err;
    assign kx.num_rounds = r_num_rounds;

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Bench for the key-schedule engine: one instance per read/width configuration, checked against a
// GF(2^8)-arithmetic model of the FIPS-197 schedule with known-answer and randomized keys.
module tb_aes_key_expand_seq;

    logic         clk;
    logic         reset;
    logic         start;
    logic [1:0]   mode;
    logic [255:0] key_in;
    logic [3:0]   rd_round;

    aes_key_expand_seq_if kx1 ();
    aes_key_expand_seq_if kx2 ();

    assign kx1.start = start;  assign kx1.mode = mode;  assign kx1.key_in = key_in;  assign kx1.rd_round = rd_round;
    assign kx2.start = start;  assign kx2.mode = mode;  assign kx2.key_in = key_in;  assign kx2.rd_round = rd_round;

    aes_key_expand_seq #(.WORDS_PER_CYCLE(1), .REG_READ(1)) u_dut_w1 (.clk(clk), .reset(reset), .kx(kx1));
    aes_key_expand_seq #(.WORDS_PER_CYCLE(2), .REG_READ(0)) u_dut_w2 (.clk(clk), .reset(reset), .kx(kx2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bit           sel;
    int           wpc;
    bit           regrd;
    logic         o_ready, o_busy, o_done, o_err, o_rd_valid;
    logic [3:0]   o_num_rounds;
    logic [127:0] o_rd_key;

    always_comb begin
        o_ready      = sel ? kx2.ready      : kx1.ready;
        o_busy       = sel ? kx2.busy       : kx1.busy;
        o_done       = sel ? kx2.done       : kx1.done;
        o_err        = sel ? kx2.err        : kx1.err;
        o_rd_valid   = sel ? kx2.rd_valid   : kx1.rd_valid;
        o_num_rounds = sel ? kx2.num_rounds : kx1.num_rounds;
        o_rd_key     = sel ? kx2.rd_key     : kx1.rd_key;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s (cfg %0d): got %h expected %h", tag, sel, act, exp);
        end
    endtask

    // Reference model: S-box from the field inverse plus affine map, schedule from FIPS-197 pseudocode.
    logic [7:0]  sbox_m [256];
    logic [31:0] mw [60];
    int          mnk, mnr, mt;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_m(input logic [31:0] w);
        return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
    endfunction

    task automatic expand(input int m, input logic [255:0] k);
        logic [31:0] t;
        logic [7:0]  rc;
        mnk = 4 + 2*m;  mnr = mnk + 6;  mt = 4*(mnr + 1);
        for (int i = 0; i < mnk; i++) mw[i] = k[255 - 32*i -: 32];
        for (int i = mnk; i < mt; i++) begin
            t = mw[i-1];
            if (i % mnk == 0) begin
                rc = 8'h01;
                for (int j = 1; j < i / mnk; j++) rc = gmul(rc, 8'h02);
                t = sub_m({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            end else if (mnk > 6 && i % mnk == 4) begin
                t = sub_m(t);
            end
            mw[i] = mw[i-mnk] ^ t;
        end
    endtask

    function automatic logic [127:0] mkey(input int r);
        return {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
    endfunction

    // Words available at cycle c after acceptance (cycle 0); reads of round r need words 4r..4r+3.
    function automatic bit valid_at(input int c, input int r);
        int wp;
        wp = (c < 2) ? 0 : mnk + (c - 2) * wpc;
        if (wp > mt) wp = mt;
        return (4*r + 3 < wp) && (r <= mnr);
    endfunction

    task automatic kick(input int m, input logic [255:0] k, input int pr);
        start = 1'b1;  mode = 2'(m);  key_in = k;  rd_round = 4'(pr);
    endtask

    task automatic run_body(input int m, input logic [255:0] k, input int pr, input bit inject);
        int c, dcyc;
        bit vexp;
        expand(m, k);
        dcyc = 1 + (mt - mnk) / wpc + 1;
        for (c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start = 1'b0;
                check_val("busy_c1", o_busy, 1);
                check_val("ready_c1", o_ready, 0);
                check_val("num_rounds_c1", o_num_rounds, mnr);
            end
            if (inject && c == 5) begin
                start = 1'b1;  mode = 2'($urandom_range(0, 3));  key_in = ~k;
            end
            if (inject && c == 6) begin
                start = 1'b0;
                check_val("err_while_busy", o_err, 0);
            end
            if (c >= 2) begin
                vexp = regrd ? valid_at(c - 1, pr) : valid_at(c, pr);
                check_val("poll_valid", o_rd_valid, vexp);
                if (vexp) check_val("poll_key", o_rd_key, mkey(pr));
            end
            if (o_done) break;
        end
        check_val("done_cycle", c, dcyc);
        check_val("ready_at_done", o_ready, 1);
        check_val("busy_at_done", o_busy, 0);
    endtask

    task automatic run_expand(input int m, input logic [255:0] k, input int pr, input bit inject);
        @(negedge clk);
        kick(m, k, pr);
        run_body(m, k, pr, inject);
    endtask

    task automatic read_round(input int r, output logic [127:0] key, output logic vld);
        @(negedge clk);
        rd_round = 4'(r);
        @(negedge clk);
        key = o_rd_key;
        vld = o_rd_valid;
    endtask

    task automatic read_all();
        logic [127:0] key;
        logic         vld;
        for (int r = 0; r < 16; r++) begin
            read_round(r, key, vld);
            check_val($sformatf("rd_valid_r%0d", r), vld, r <= mnr);
            if (r <= mnr) check_val($sformatf("rd_key_r%0d", r), key, mkey(r));
        end
    endtask

    function automatic logic [255:0] rnd_key();
        return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    initial begin
        logic [127:0] key;
        logic         vld;
        int           m, ndone;

        reset = 1'b0;  start = 1'b0;  mode = 2'b00;  key_in = '0;  rd_round = '0;
        build_sbox();

        for (int cfg = 0; cfg < 2; cfg++) begin
            sel   = cfg[0];
            wpc   = (cfg == 0) ? 1 : 2;
            regrd = (cfg == 0);

            @(negedge clk);
            reset = 1'b1;  start = 1'b0;  rd_round = '0;
            @(negedge clk);
            @(negedge clk);
            check_val("rst_ready", o_ready, 1);
            check_val("rst_busy", o_busy, 0);
            check_val("rst_done", o_done, 0);
            check_val("rst_err", o_err, 0);
            check_val("rst_num_rounds", o_num_rounds, 10);
            check_val("rst_rd_valid", o_rd_valid, 0);
            check_val("rst_rd_key", o_rd_key, 0);
            reset = 1'b0;

            run_expand(0, K128, 2, 1'b0);
            read_round(1, key, vld);
            check_val("kat128_r1", key, 128'ha0fafe1788542cb123a339392a6c7605);
            read_round(10, key, vld);
            check_val("kat128_r10", key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
            read_all();

            run_expand(0, rnd_key(), 11, 1'b0);
            read_round(11, key, vld);
            check_val("r11_after_128", vld, 0);

            run_expand(1, K192, 5, 1'b1);
            check_val("kat192_num_rounds", o_num_rounds, 12);
            read_round(12, key, vld);
            check_val("kat192_r12", key, 128'he98ba06f448c773c8ecc720401002202);
            read_all();

            run_expand(2, K256, 14, 1'b0);
            read_round(14, key, vld);
            check_val("kat256_r14", key, 128'hfe4890d1e6188d0b046df344706c631e);

            @(negedge clk);
            start = 1'b1;  mode = 2'b11;  key_in = rnd_key();
            @(negedge clk);
            start = 1'b0;
            check_val("illegal_err", o_err, 1);
            check_val("illegal_ready", o_ready, 1);
            check_val("illegal_busy", o_busy, 0);
            @(negedge clk);
            check_val("illegal_err_pulse", o_err, 0);
            check_val("illegal_num_rounds", o_num_rounds, mnr);
            read_all();

            // Back-to-back: the next start is presented in the done cycle itself.
            run_expand(0, rnd_key(), 0, 1'b0);
            m = $urandom_range(0, 2);
            kick(m, rnd_key(), $urandom_range(0, 15));
            run_body(m, key_in, int'(rd_round), 1'b0);
            read_all();

            for (int t = 0; t < 8; t++) begin
                m = $urandom_range(0, 2);
                run_expand(m, rnd_key(), $urandom_range(0, 15), 1'($urandom_range(0, 1)));
                read_all();
            end

            @(negedge clk);
            kick(2, rnd_key(), 0);
            for (int c = 1; c <= 20; c++) begin
                @(negedge clk);
                if (c == 1) start = 1'b0;
            end
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            check_val("midrst_ready", o_ready, 1);
            check_val("midrst_busy", o_busy, 0);
            check_val("midrst_rd_valid", o_rd_valid, 0);
            ndone = 0;
            for (int c = 0; c < 60; c++) begin
                @(negedge clk);
                if (o_done) ndone++;
            end
            check_val("midrst_no_done", ndone, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
